// File: rtl/extrema_pkg.sv
// rtl/extrema_pkg.sv - shared types and constants for the stream extrema tracker
package extrema_pkg;

    localparam int EXT_WIDTH = 8;
    localparam int EXT_IDX_W = 8;
    // Sample count saturates at 2^IDX_W; the extra count bit holds this value.
    localparam int SAT_COUNT = 1 << EXT_IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [EXT_WIDTH-1:0] max;
        logic [EXT_WIDTH-1:0] min;
        logic [EXT_IDX_W-1:0] max_idx;
        logic [EXT_IDX_W-1:0] min_idx;
        logic [EXT_IDX_W:0]   count;
        logic                 ovf;
    } extrema_res_t;

    // Saturation value for an arbitrary index width.
    function automatic int unsigned sat_count(input int unsigned idx_w);
        return 32'd1 << idx_w;
    endfunction

endpackage

// File: rtl/comp.sv
// rtl/comp.sv - unsigned magnitude comparator
module comp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gr,
    output logic             ls
);

    assign gr = (a > b);
    assign ls = (a < b);

endmodule

// File: rtl/stream_extrema_tracker.sv
// rtl/stream_extrema_tracker.sv - framed running max/min/index/count reducer; EXTREMA_SIGNED_EN selects signed ordering
module stream_extrema_tracker
    import extrema_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    output logic [IDX_W-1:0] res_max_idx,
    output logic [IDX_W-1:0] res_min_idx,
    output logic [IDX_W:0]   res_count,
    output logic             res_ovf
);

    localparam logic [IDX_W:0]   SAT      = (IDX_W+1)'(sat_count(IDX_W));
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             res_valid_q, res_valid_d;

    logic             in_xfer;
    logic             res_xfer;
    logic             gt_max, lt_min;
    logic             max_ls_unused, min_gr_unused;
    logic [WIDTH-1:0] cmp_in, cmp_max_op, cmp_min_op;
    logic [IDX_W-1:0] new_idx;

    // Ready is held low during reset and while a result waits in DONE.
    assign in_ready  = ~rst & (state_q != DONE);
    assign in_xfer   = in_valid & in_ready;
    assign res_xfer  = res_valid_q & res_ready;
    assign new_idx   = (count_q == SAT) ? IDX_LAST : count_q[IDX_W-1:0];

`ifdef EXTREMA_SIGNED_EN
    // Flipping the MSB maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
    assign cmp_in     = in_data ^ SIGN_FLIP;
    assign cmp_max_op = max_q ^ SIGN_FLIP;
    assign cmp_min_op = min_q ^ SIGN_FLIP;
`else
    assign cmp_in     = in_data;
    assign cmp_max_op = max_q;
    assign cmp_min_op = min_q;
`endif

    comp #(.WIDTH(WIDTH)) cmp_max (
        .a  (cmp_in),
        .b  (cmp_max_op),
        .gr (gt_max),
        .ls (max_ls_unused)
    );

    comp #(.WIDTH(WIDTH)) cmp_min (
        .a  (cmp_in),
        .b  (cmp_min_op),
        .gr (min_gr_unused),
        .ls (lt_min)
    );

    // Next-state and running-result update for IDLE/ACCUM/DONE.
    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        min_d       = min_q;
        max_idx_d   = max_idx_q;
        min_idx_d   = min_idx_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    max_d     = in_data;
                    min_d     = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    count_d   = (IDX_W+1)'(1);
                    ovf_d     = 1'b0;
                    state_d   = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    // Strict compares keep the first occurrence on ties.
                    if (gt_max) begin
                        max_d     = in_data;
                        max_idx_d = new_idx;
                    end
                    if (lt_min) begin
                        min_d     = in_data;
                        min_idx_d = new_idx;
                    end
                    if (count_q == SAT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_xfer) begin
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        res_valid_d = (state_d == DONE);
    end

    // State and result registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            max_q       <= '0;
            min_q       <= '0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            max_idx_q   <= max_idx_d;
            min_idx_q   <= min_idx_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_max     = max_q;
    assign res_min     = min_q;
    assign res_max_idx = max_idx_q;
    assign res_min_idx = min_idx_q;
    assign res_count   = count_q;
    assign res_ovf     = ovf_q;

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// tb/tb_stream_extrema_tracker.sv - self-checking bench for stream_extrema_tracker
module tb_stream_extrema_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       in_valid, in_ready, in_last, res_valid, res_ready, res_ovf;
    logic [7:0] in_data, res_max, res_min, res_max_idx, res_min_idx;
    logic [8:0] res_count;

    logic       s_in_valid, s_in_ready, s_in_last, s_res_valid, s_res_ready, s_res_ovf;
    logic [7:0] s_in_data, s_res_max, s_res_min;
    logic [1:0] s_res_max_idx, s_res_min_idx;
    logic [2:0] s_res_count;

    int total = 0;
    int bad   = 0;

    stream_extrema_tracker #(.WIDTH(8), .IDX_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_max(res_max), .res_min(res_min),
        .res_max_idx(res_max_idx), .res_min_idx(res_min_idx),
        .res_count(res_count), .res_ovf(res_ovf)
    );

    stream_extrema_tracker #(.WIDTH(8), .IDX_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_max(s_res_max), .res_min(s_res_min),
        .res_max_idx(s_res_max_idx), .res_min_idx(s_res_min_idx),
        .res_count(s_res_count), .res_ovf(s_res_ovf)
    );

    typedef struct {
        logic [7:0] mx;
        logic [7:0] mn;
        int         mxi;
        int         mni;
        int         cnt;
        int         ovf;
    } res_t;

    typedef struct {
        int         n;
        logic [7:0] s[5];
        logic [7:0] mx;
        logic [7:0] mn;
        int         mxi;
        int         mni;
        int         cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ordering key: the numeric value the sample represents.
    function automatic int skey(input logic [7:0] v);
`ifdef EXTREMA_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    // Reference: scan the whole frame, first occurrence wins, indices clip at 2^idx_w-1.
    function automatic res_t model(input logic [7:0] f[$], input int idx_w);
        res_t r;
        int   sat = 1 << idx_w;
        r.mx  = f[0];
        r.mn  = f[0];
        r.mxi = 0;
        r.mni = 0;
        for (int i = 1; i < f.size(); i++) begin
            if (skey(f[i]) > skey(r.mx)) begin
                r.mx  = f[i];
                r.mxi = (i < sat) ? i : sat - 1;
            end
            if (skey(f[i]) < skey(r.mn)) begin
                r.mn  = f[i];
                r.mni = (i < sat) ? i : sat - 1;
            end
        end
        r.cnt = (f.size() > sat) ? sat : f.size();
        r.ovf = (f.size() > sat) ? 1 : 0;
        return r;
    endfunction

    function automatic int pick_len();
        if ($urandom_range(0, 99) == 0) return int'($urandom_range(250, 270));
        return int'($urandom_range(1, 12));
    endfunction

    // Drive one frame on the main DUT; returns at the negedge after the last transfer.
    task automatic send_frame(input logic [7:0] f[$]);
        for (int i = 0; i < f.size(); i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = f[i];
            in_last  = (i == f.size() - 1);
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
            if (i == f.size() - 1) check("pre_last_res_valid", 32'(res_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("latency_res_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("consumed_res_valid", 32'(res_valid), 32'd0);
    endtask

    vec_t       vecs[7];
    logic [7:0] fq[$];
    res_t       expq[$];
    logic [7:0] cur[$];
    res_t       r;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_res_ready = 1'b0;

        vecs[0] = '{n: 5, s: '{8'd3, 8'd9, 8'd1, 8'd9, 8'd4}, mx: 8'd9, mn: 8'd1, mxi: 1, mni: 2, cnt: 5};
        vecs[1] = '{n: 1, s: '{8'h80, 8'd0, 8'd0, 8'd0, 8'd0}, mx: 8'h80, mn: 8'h80, mxi: 0, mni: 0, cnt: 1};
        vecs[2] = '{n: 2, s: '{8'd2, 8'd6, 8'd0, 8'd0, 8'd0}, mx: 8'd6, mn: 8'd2, mxi: 1, mni: 0, cnt: 2};
        vecs[3] = '{n: 3, s: '{8'd5, 8'd5, 8'd5, 8'd0, 8'd0}, mx: 8'd5, mn: 8'd5, mxi: 0, mni: 0, cnt: 3};
`ifdef EXTREMA_SIGNED_EN
        vecs[4] = '{n: 2, s: '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0}, mx: 8'd0, mn: 8'd255, mxi: 0, mni: 1, cnt: 2};
        vecs[5] = '{n: 2, s: '{8'h80, 8'h7F, 8'd0, 8'd0, 8'd0}, mx: 8'h7F, mn: 8'h80, mxi: 1, mni: 0, cnt: 2};
        vecs[6] = '{n: 5, s: '{8'd200, 8'd10, 8'd250, 8'd10, 8'd250}, mx: 8'd10, mn: 8'd200, mxi: 1, mni: 0, cnt: 5};
`else
        vecs[4] = '{n: 2, s: '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0}, mx: 8'd255, mn: 8'd0, mxi: 1, mni: 0, cnt: 2};
        vecs[5] = '{n: 2, s: '{8'h80, 8'h7F, 8'd0, 8'd0, 8'd0}, mx: 8'h80, mn: 8'h7F, mxi: 0, mni: 1, cnt: 2};
        vecs[6] = '{n: 5, s: '{8'd200, 8'd10, 8'd250, 8'd10, 8'd250}, mx: 8'd250, mn: 8'd10, mxi: 2, mni: 1, cnt: 5};
`endif

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_res_max", 32'(res_max), 32'd0);
        check("rst_res_ovf", 32'(res_ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            fq.delete();
            for (int k = 0; k < vecs[v].n; k++) fq.push_back(vecs[v].s[k]);
            send_frame(fq);
            check($sformatf("vec%0d_max", v), 32'(res_max), 32'(vecs[v].mx));
            check($sformatf("vec%0d_min", v), 32'(res_min), 32'(vecs[v].mn));
            check($sformatf("vec%0d_max_idx", v), 32'(res_max_idx), 32'(vecs[v].mxi));
            check($sformatf("vec%0d_min_idx", v), 32'(res_min_idx), 32'(vecs[v].mni));
            check($sformatf("vec%0d_count", v), 32'(res_count), 32'(vecs[v].cnt));
            check($sformatf("vec%0d_ovf", v), 32'(res_ovf), 32'd0);
            consume();
        end

        // Backpressure in DONE with in_valid held high
        fq = '{8'd4, 8'd1};
        send_frame(fq);
        in_valid = 1'b1;
        in_data  = 8'd99;
        in_last  = 1'b1;
        begin
            int ready_seen;
            ready_seen = 0;
            for (int c = 0; c < 10; c++) begin
                if (in_ready) ready_seen++;
                @(negedge clk);
            end
            check("bp_in_ready_low", 32'(ready_seen), 32'd0);
        end
        check("bp_max_hold", 32'(res_max), 32'd4);
        check("bp_min_hold", 32'(res_min), 32'd1);
        check("bp_count_hold", 32'(res_count), 32'd2);
        check("bp_valid_hold", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_after_xfer_valid", 32'(res_valid), 32'd0);
        check("bp_after_xfer_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_next_valid", 32'(res_valid), 32'd1);
        check("bp_next_max", 32'(res_max), 32'd99);
        check("bp_next_count", 32'(res_count), 32'd1);
        consume();

        // Count saturation and overflow on the IDX_W=2 instance
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_data  = 8'(i);
            s_in_last  = (i == 5);
            @(posedge clk);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        check("sat_valid", 32'(s_res_valid), 32'd1);
        check("sat_count", 32'(s_res_count), 32'd4);
        check("sat_ovf", 32'(s_res_ovf), 32'd1);
        check("sat_max", 32'(s_res_max), 32'd5);
        check("sat_max_idx", 32'(s_res_max_idx), 32'd3);
        check("sat_min", 32'(s_res_min), 32'd1);
        check("sat_min_idx", 32'(s_res_min_idx), 32'd0);
        s_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_res_ready = 1'b0;
        check("sat_ovf_cleared", 32'(s_res_ovf), 32'd0);
        s_in_valid = 1'b1;
        s_in_data  = 8'd7;
        s_in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        check("sat_next_valid", 32'(s_res_valid), 32'd1);
        check("sat_next_ovf", 32'(s_res_ovf), 32'd0);
        check("sat_next_count", 32'(s_res_count), 32'd1);
        s_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_res_ready = 1'b0;

        // Reset mid-frame discards the partial frame
        in_valid = 1'b1; in_data = 8'd7; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'd8;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_count", 32'(res_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int valid_seen;
            valid_seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (res_valid) valid_seen++;
            end
            check("midrst_no_result", 32'(valid_seen), 32'd0);
        end
        fq = '{8'd2, 8'd6};
        send_frame(fq);
        check("postrst_max", 32'(res_max), 32'd6);
        check("postrst_max_idx", 32'(res_max_idx), 32'd1);
        check("postrst_min", 32'(res_min), 32'd2);
        check("postrst_min_idx", 32'(res_min_idx), 32'd0);
        check("postrst_count", 32'(res_count), 32'd2);
        consume();

        // Randomized frames with valid gaps and result backpressure
        begin
            int nfr, sent, got, cycles, flen;
            nfr = 1000; sent = 0; got = 0; cycles = 0;
            flen = pick_len();
            expq.delete();
            cur.delete();
            while (got < nfr && cycles < 60000) begin
                res_ready = ($urandom_range(0, 3) != 0);
                if (res_valid && res_ready) begin
                    if (expq.size() == 0) begin
                        check("rand_extra_beat", 32'd1, 32'd0);
                    end else begin
                        r = expq.pop_front();
                        check("rand_max", 32'(res_max), 32'(r.mx));
                        check("rand_min", 32'(res_min), 32'(r.mn));
                        check("rand_max_idx", 32'(res_max_idx), 32'(r.mxi));
                        check("rand_min_idx", 32'(res_min_idx), 32'(r.mni));
                        check("rand_count", 32'(res_count), 32'(r.cnt));
                        check("rand_ovf", 32'(res_ovf), 32'(r.ovf));
                        got++;
                    end
                end
                if (sent < nfr && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(126, 129));
                    in_last  = (cur.size() == flen - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                if (in_valid && in_ready) begin
                    cur.push_back(in_data);
                    if (in_last) begin
                        expq.push_back(model(cur, 8));
                        cur.delete();
                        sent++;
                        flen = pick_len();
                    end
                end
                @(posedge clk);
                @(negedge clk);
                cycles++;
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            res_ready = 1'b0;
            check("rand_frames_received", 32'(got), 32'(nfr));
            check("rand_pending_results", 32'(expq.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
